out_fm_fifo_to_ram: RTL and testbench
=====================================

# out_fm_fifo_to_ram

Drains one output-feature-map tile from the out_fm FIFO and writes it into the out_fm RAM when `start` is pulsed; pulses `done` after the last RAM write. Counterpart of the RAM-to-in_fm-FIFO mover: sits between the compute array's output FIFO and the on-chip out_fm[M][R][C] buffer, stored row-major. Tile elements outside the feature-map bounds are popped and discarded.

## Interface
- AW, 32, address/counter width
- DW, 32, data width
- M, 32, feature maps in full out_fm
- R, 64, rows in full out_fm
- C, 32, columns in full out_fm
- Tm, 8, tile depth
- Tr, 16, tile rows
- Tc, 8, tile columns

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- start  in  1  one-cycle pulse, begins a tile transfer when idle
- done  out  1  one-cycle pulse after final write
- fifo_pop  out  1  pop request; FIFO data valid on `data_from_fifo` next cycle
- fifo_empty  in  1  FIFO has no data
- data_from_fifo  in  DW  FIFO read data
- ram_wena  out  1  RAM write enable
- ram_addr  out  AW  RAM write address
- data_to_ram  out  DW  RAM write data
- tile_base_m, tile_base_row, tile_base_col  in  AW each  tile origin; sampled on accepted `start`

## Operation
- FSM: IDLE -> RUN on `start`; RUN -> DRAIN when Tm*Tr*Tc pops issued; DRAIN -> DONE when pipeline empty (2 cycles); DONE -> IDLE unconditionally (done=1 in DONE only).
- `start` outside IDLE ignored. Tile bases latched on accepted start.
- fifo_pop = (state==RUN) && !fifo_empty. Exactly Tm*Tr*Tc pops per tile, never more.
- Counters tc (inner, 0..Tc-1), tr, tm (outer) advance on each pop; wrap tc->tr->tm.
- Per pop, legal = (base_m+tm<M) && (base_row+tr<R) && (base_col+tc<C).
- Address = (base_m+tm)*R*C + (base_row+tr)*C + (base_col+tc), computed in AW bits, truncating.
- Illegal elements: popped, ram_wena stays 0.

## Timing
- Reset values: fifo_pop=0, ram_wena=0, ram_addr=0, data_to_ram=0, done=0, state=IDLE, counters=0.
- Pop at cycle t -> address/legal registered at t+1 alongside FIFO data -> ram_wena/ram_addr/data_to_ram registered outputs at t+2. Latency pop-to-write: 2 cycles.
- Last pop at t_last -> last write at t_last+2 -> done at t_last+3.
- fifo_empty stalls pops and counters only; in-flight writes complete; order preserved.
- data_to_ram holds last value when ram_wena=0.
- rst low mid-transfer: immediate return to reset values; no further pops/writes; partial tile abandoned.
- start coincident with done: ignored (not IDLE).

## Structure
- Shared package: state encoding (IDLE/RUN/DRAIN/DONE) and tile-size derived constant TILE_SIZE=Tm*Tr*Tc.
- One sub-module: out_tile_addr_gen (nested 3-level counter + legality + address, registered output, enabled by pop). FSM and write pipeline in top.

## Test plan
Bench params M=4, R=6, C=6, Tm=2, Tr=4, Tc=4; FIFO model returns incrementing words 0,1,2...
- Base (0,0,0), FIFO full -> 32 pops, 32 writes; first addr 0 data 0; element tm=1,tr=0,tc=0 at addr 36 data 16; done exactly 3 cycles after last pop.
- Edge tile base (2,4,4) -> 32 pops, 8 writes (tr,tc∈{0,1}); first addr 100 data 0; element tr=0,tc=2 popped, no write.
- fifo_empty asserted every other cycle -> pops only when non-empty, RAM contents identical to scenario 1, total cycles ~doubled.
- start pulsed again mid-RUN and in DONE cycle -> ignored; exactly one done per accepted start.
- rst low after 10 pops -> all outputs 0 same cycle; after release, new start on base (0,0,0) completes normally.
- Back-to-back tiles: start in cycle after done -> second tile accepted, writes contiguous and correct.

Source files
------------

// File: rtl/out_fm_fifo_to_ram_pkg.sv
// Shared types and constants for the out_fm FIFO-to-RAM mover.
package out_fm_fifo_to_ram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned DEF_TM = 8;
    localparam int unsigned DEF_TR = 16;
    localparam int unsigned DEF_TC = 8;

    function automatic int unsigned tile_size(input int unsigned tm, input int unsigned tr,
                                              input int unsigned tc);
        return tm * tr * tc;
    endfunction

    localparam int unsigned TILE_SIZE = tile_size(DEF_TM, DEF_TR, DEF_TC);

endpackage

// File: rtl/out_tile_addr_gen.sv
// Nested tm/tr/tc tile counter with bounds check and row-major RAM address.
// Outputs are registered and advance only on pop, so they line up with FIFO read data.
module out_tile_addr_gen #(
    parameter int unsigned AW = 32,
    parameter int unsigned M  = 32,
    parameter int unsigned R  = 64,
    parameter int unsigned C  = 32,
    parameter int unsigned Tm = 8,
    parameter int unsigned Tr = 16,
    parameter int unsigned Tc = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          pop_i,
    input  logic [AW-1:0] base_m_i,
    input  logic [AW-1:0] base_row_i,
    input  logic [AW-1:0] base_col_i,
    output logic          vld_o,
    output logic          legal_o,
    output logic [AW-1:0] addr_o
);

    logic [AW-1:0] tm_q, tm_d, tr_q, tr_d, tc_q, tc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          legal_q, legal_d;
    logic          vld_q, vld_d;
    logic [AW-1:0] m_abs, r_abs, c_abs;

    always_comb begin
        m_abs   = base_m_i + tm_q;
        r_abs   = base_row_i + tr_q;
        c_abs   = base_col_i + tc_q;
        tm_d    = tm_q;
        tr_d    = tr_q;
        tc_d    = tc_q;
        addr_d  = addr_q;
        legal_d = legal_q;
        vld_d   = pop_i;
        if (clr_i) begin
            tm_d = '0;
            tr_d = '0;
            tc_d = '0;
        end else if (pop_i) begin
            legal_d = (m_abs < AW'(M)) && (r_abs < AW'(R)) && (c_abs < AW'(C));
            addr_d  = m_abs * AW'(R * C) + r_abs * AW'(C) + c_abs;
            // tc is innermost, tm outermost
            if (tc_q == AW'(Tc - 1)) begin
                tc_d = '0;
                if (tr_q == AW'(Tr - 1)) begin
                    tr_d = '0;
                    tm_d = (tm_q == AW'(Tm - 1)) ? '0 : tm_q + 1'b1;
                end else begin
                    tr_d = tr_q + 1'b1;
                end
            end else begin
                tc_d = tc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tm_q    <= '0;
            tr_q    <= '0;
            tc_q    <= '0;
            addr_q  <= '0;
            legal_q <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            tm_q    <= tm_d;
            tr_q    <= tr_d;
            tc_q    <= tc_d;
            addr_q  <= addr_d;
            legal_q <= legal_d;
            vld_q   <= vld_d;
        end
    end

    assign vld_o   = vld_q;
    assign legal_o = legal_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/out_fm_fifo_to_ram.sv
// Drains one out_fm tile from the output FIFO into the out_fm RAM, discarding
// elements that fall outside the feature-map bounds; pulses done after the last write.
module out_fm_fifo_to_ram
    import out_fm_fifo_to_ram_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned M  = 32,
    parameter int unsigned R  = 64,
    parameter int unsigned C  = 32,
    parameter int unsigned Tm = DEF_TM,
    parameter int unsigned Tr = DEF_TR,
    parameter int unsigned Tc = DEF_TC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    output logic          fifo_pop,
    input  logic          fifo_empty,
    input  logic [DW-1:0] data_from_fifo,
    output logic          ram_wena,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] data_to_ram,
    input  logic [AW-1:0] tile_base_m,
    input  logic [AW-1:0] tile_base_row,
    input  logic [AW-1:0] tile_base_col
);

    localparam int unsigned TileSize = tile_size(Tm, Tr, Tc);

    state_e        state_q, state_d;
    logic [AW-1:0] pop_cnt_q, pop_cnt_d;
    logic          drain_q, drain_d;
    logic [AW-1:0] base_m_q, base_m_d, base_row_q, base_row_d, base_col_q, base_col_d;
    logic          ram_wena_q, ram_wena_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          clr;
    logic          gen_vld, gen_legal;
    logic [AW-1:0] gen_addr;

    always_comb begin
        state_d    = state_q;
        pop_cnt_d  = pop_cnt_q;
        drain_d    = drain_q;
        base_m_d   = base_m_q;
        base_row_d = base_row_q;
        base_col_d = base_col_q;
        fifo_pop   = 1'b0;
        clr        = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    pop_cnt_d  = '0;
                    base_m_d   = tile_base_m;
                    base_row_d = tile_base_row;
                    base_col_d = tile_base_col;
                    clr        = 1'b1;
                end
            end
            StRun: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    pop_cnt_d = pop_cnt_q + 1'b1;
                    if (pop_cnt_q == AW'(TileSize - 1)) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                // two cycles: lets the final pop reach the RAM write register
                drain_d = 1'b1;
                if (drain_q) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_wena_d = gen_vld && gen_legal;
        ram_addr_d = ram_wena_d ? gen_addr : ram_addr_q;
        data_d     = ram_wena_d ? data_from_fifo : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            pop_cnt_q  <= '0;
            drain_q    <= 1'b0;
            base_m_q   <= '0;
            base_row_q <= '0;
            base_col_q <= '0;
            ram_wena_q <= 1'b0;
            ram_addr_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            pop_cnt_q  <= pop_cnt_d;
            drain_q    <= drain_d;
            base_m_q   <= base_m_d;
            base_row_q <= base_row_d;
            base_col_q <= base_col_d;
            ram_wena_q <= ram_wena_d;
            ram_addr_q <= ram_addr_d;
            data_q     <= data_d;
        end
    end

    out_tile_addr_gen #(
        .AW (AW),
        .M  (M),
        .R  (R),
        .C  (C),
        .Tm (Tm),
        .Tr (Tr),
        .Tc (Tc)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .pop_i      (fifo_pop),
        .base_m_i   (base_m_q),
        .base_row_i (base_row_q),
        .base_col_i (base_col_q),
        .vld_o      (gen_vld),
        .legal_o    (gen_legal),
        .addr_o     (gen_addr)
    );

    assign ram_wena    = ram_wena_q;
    assign ram_addr    = ram_addr_q;
    assign data_to_ram = data_q;

endmodule

// File: tb/tb_out_fm_fifo_to_ram.sv
// Scoreboard bench for out_fm_fifo_to_ram on a 4x6x6 feature map with 2x4x4 tiles.
module tb_out_fm_fifo_to_ram;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int M  = 4;
    localparam int R  = 6;
    localparam int C  = 6;
    localparam int TM = 2;
    localparam int TR = 4;
    localparam int TC = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic          fifo_pop;
    logic          fifo_empty = 1'b0;
    logic [DW-1:0] data_from_fifo = '0;
    logic          ram_wena;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] data_to_ram;
    logic [AW-1:0] tile_base_m = '0;
    logic [AW-1:0] tile_base_row = '0;
    logic [AW-1:0] tile_base_col = '0;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cycle = 0;
    int          last_pop = 0;
    int          pop_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic        empty_mode = 1'b0;
    logic        fifo_rewind = 1'b0;
    logic [31:0] fifo_next = '0;
    exp_t        exp_q[$];
    logic [31:0] ram_img[int unsigned];
    logic [31:0] img1[int unsigned];

    out_fm_fifo_to_ram #(
        .AW (AW), .DW (DW), .M (M), .R (R), .C (C), .Tm (TM), .Tr (TR), .Tc (TC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .done           (done),
        .fifo_pop       (fifo_pop),
        .fifo_empty     (fifo_empty),
        .data_from_fifo (data_from_fifo),
        .ram_wena       (ram_wena),
        .ram_addr       (ram_addr),
        .data_to_ram    (data_to_ram),
        .tile_base_m    (tile_base_m),
        .tile_base_row  (tile_base_row),
        .tile_base_col  (tile_base_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // FIFO model: incrementing words, data valid the cycle after the pop
    always @(posedge clk) begin
        if (fifo_rewind) begin
            fifo_next <= '0;
        end else if (fifo_pop) begin
            data_from_fifo <= fifo_next;
            fifo_next      <= fifo_next + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        fifo_empty = empty_mode ? !fifo_empty : 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (fifo_pop) begin
                pop_cnt++;
                last_pop = cycle;
            end
            if (ram_wena) begin
                wr_cnt++;
                ram_img[ram_addr] = data_to_ram;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %0d required none",
                             ram_addr, data_to_ram);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", ram_addr, e.addr);
                    check("wr_data", data_to_ram, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_latency", cycle - last_pop, 3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        ram_img.delete();
        pop_cnt  = 0;
        wr_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic push_tile(input int bm, input int br, input int bc);
        for (int tm = 0; tm < TM; tm++)
            for (int tr = 0; tr < TR; tr++)
                for (int tc = 0; tc < TC; tc++) begin
                    exp_t e;
                    if (bm + tm < M && br + tr < R && bc + tc < C) begin
                        e.addr = (bm + tm) * R * C + (br + tr) * C + (bc + tc);
                        e.data = tm * TR * TC + tr * TC + tc;
                        exp_q.push_back(e);
                    end
                end
    endtask

    task automatic pulse_start(input int bm, input int br, input int bc, output int c0);
        tile_base_m   = bm;
        tile_base_row = br;
        tile_base_col = bc;
        c0            = cycle;
        start         = 1'b1;
        fifo_rewind   = 1'b1;
        tick();
        start         = 1'b0;
        fifo_rewind   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                at = cycle;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done required done within %0d cycles", budget);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, d, d2;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pop", fifo_pop, 0);
        check("rst_wena", ram_wena, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", data_to_ram, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        tick();

        // S1: base (0,0,0), FIFO always ready
        clear_stats();
        push_tile(0, 0, 0);
        pulse_start(0, 0, 0, c0);
        wait_done(200, d);
        check("s1_duration", d - c0, 35);
        check("s1_pops", pop_cnt, 32);
        check("s1_writes", wr_cnt, 32);
        check("s1_addr0", ram_img[0], 0);
        check("s1_addr36", ram_img[36], 16);
        check("s1_queue", exp_q.size(), 0);
        img1 = ram_img;

        // S2: edge tile, only tr,tc in {0,1} land in bounds
        clear_stats();
        push_tile(2, 4, 4);
        pulse_start(2, 4, 4, c0);
        wait_done(200, d);
        check("s2_pops", pop_cnt, 32);
        check("s2_writes", wr_cnt, 8);
        check("s2_addr100", ram_img[100], 0);
        check("s2_addr143", ram_img[143], 21);
        check("s2_no_addr102", ram_img.exists(102), 0);
        check("s2_queue", exp_q.size(), 0);

        // S3: FIFO empty every other cycle
        clear_stats();
        empty_mode = 1'b1;
        push_tile(0, 0, 0);
        pulse_start(0, 0, 0, c0);
        wait_done(300, d);
        empty_mode = 1'b0;
        check("s3_duration", (d - c0 >= 66) && (d - c0 <= 67), 1);
        check("s3_pops", pop_cnt, 32);
        check("s3_size", ram_img.num(), 32);
        foreach (img1[a]) begin
            check("s3_exists", ram_img.exists(a), 1);
            if (ram_img.exists(a)) check("s3_data", ram_img[a], img1[a]);
        end
        check("s3_queue", exp_q.size(), 0);
        repeat (2) tick();

        // S4: start mid-RUN and in the DONE cycle are both ignored
        clear_stats();
        push_tile(1, 2, 2);
        pulse_start(1, 2, 2, c0);
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (25) tick();
        start = 1'b1;
        @(negedge clk);
        check("s4_done_at_35", done, 1);
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("s4_done_count", done_cnt, 1);
        check("s4_pops", pop_cnt, 32);
        check("s4_writes", wr_cnt, 32);
        check("s4_queue", exp_q.size(), 0);

        // S5: reset after 10 pops, then a clean tile
        clear_stats();
        push_tile(0, 0, 0);
        pulse_start(0, 0, 0, c0);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("s5_pop", fifo_pop, 0);
        check("s5_wena", ram_wena, 0);
        check("s5_addr", ram_addr, 0);
        check("s5_data", data_to_ram, 0);
        check("s5_done", done, 0);
        check("s5_pops", pop_cnt, 10);
        check("s5_writes", wr_cnt, 8);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        clear_stats();
        push_tile(0, 0, 0);
        pulse_start(0, 0, 0, c0);
        wait_done(200, d);
        check("s5b_writes", wr_cnt, 32);
        check("s5b_addr36", ram_img[36], 16);
        check("s5b_queue", exp_q.size(), 0);

        // S6: back-to-back tiles, second start the cycle after done
        clear_stats();
        push_tile(0, 0, 0);
        push_tile(0, 2, 0);
        pulse_start(0, 0, 0, c0);
        wait_done(200, d);
        pulse_start(0, 2, 0, c1);
        check("s6_start_gap", c1 - d, 1);
        wait_done(200, d2);
        check("s6_duration2", d2 - c1, 35);
        check("s6_done_count", done_cnt, 2);
        check("s6_pops", pop_cnt, 64);
        check("s6_writes", wr_cnt, 64);
        check("s6_addr12", ram_img[12], 0);
        check("s6_addr69", ram_img[69], 31);
        check("s6_size", ram_img.num(), 48);
        check("s6_queue", exp_q.size(), 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
